// File: rtl/irrigation_display_scan.sv
// Seven-segment scan driver: double-buffered codes, frame-synchronous
// commit, optional per-digit blink (IRRIG_DISPLAY_BLINK_EN).
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : strobe, captures codes_in/blink_in into pending buffer
//   codes_in       : 3-bit symbol per digit, digit k at [3k+2:3k]
//   blink_in       : per-digit blink mask (used only with the macro)
//   pending        : captured data waiting for the next frame boundary
//   frame_start    : high in the cycle the scan wraps back to digit 0
//   seg, an        : registered active-low segments / one-hot digit enable
module irrigation_display_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [3*DIGITS-1:0]   codes_in,
  input  logic [DIGITS-1:0]     blink_in,
  output logic                  pending,
  output logic                  frame_start,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] glyph(input logic [2:0] c);
    logic [6:0] g;
    unique case (c)
      3'b000:  g = 7'h7F;
      3'b001:  g = 7'h08;
      3'b010:  g = 7'h42;
      3'b011:  g = 7'h3F;
      3'b100:  g = 7'h06;
      3'b101:  g = 7'h47;
      3'b110:  g = 7'h09;
      default: g = 7'h41;
    endcase
    return g;
  endfunction

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][2:0]   pcode_q, pcode_d;
  logic [DIGITS-1:0][2:0]   acode_q, acode_d;
  logic                     pend_q, pend_d;
  logic [6:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic                     wrap, last, bnd, blank;

  assign wrap = (cnt_q == CW'(SCAN_DIV - 1));
  assign last = (idx_q == IW'(DIGITS - 1));
  assign bnd  = wrap & last;

`ifdef IRRIG_DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0] pblk_q, pblk_d;
  logic [DIGITS-1:0] ablk_q, ablk_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    pblk_d  = pblk_q;
    ablk_d  = ablk_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (load) pblk_d = blink_in;
    if (bnd) begin
      if (load)        ablk_d = blink_in;
      else if (pend_q) ablk_d = pblk_q;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Blink uses the active mask, so it also waits for the frame commit.
  assign blank = phase_q & ablk_q[idx_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      pblk_q  <= '0;
      ablk_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pblk_q  <= pblk_d;
      ablk_q  <= ablk_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_in;
  assign blank        = 1'b0;
`endif

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    if (wrap) idx_d = last ? '0 : idx_q + IW'(1);
    pcode_d = pcode_q;
    acode_d = acode_q;
    pend_d  = pend_q;
    if (load) begin
      pcode_d = codes_in;
      pend_d  = 1'b1;
    end
    // A load on the boundary bypasses the pending stage entirely.
    if (bnd) begin
      pend_d = 1'b0;
      if (load)        acode_d = codes_in;
      else if (pend_q) acode_d = pcode_q;
    end
    seg_d = blank ? 7'h7F : glyph(acode_q[idx_q]);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pcode_q <= '0;
      acode_q <= '0;
      pend_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pcode_q <= pcode_d;
      acode_q <= acode_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign pending     = pend_q;
  assign frame_start = bnd & ~reset;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

// File: tb/tb_irrigation_display_scan.sv
// Random-stimulus bench for irrigation_display_scan
// against a cycle-count based reference model.
module tb_irrigation_display_scan;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = D * SD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [3*D-1:0] codes = '0;
  logic [D-1:0]   blink = '0;
  logic           pending, frame_start;
  logic [6:0]     seg;
  logic [D-1:0]   an;

  int checks = 0;
  int errors = 0;

  irrigation_display_scan #(
    .DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(rst), .load(load),
    .codes_in(codes), .blink_in(blink),
    .pending(pending), .frame_start(frame_start),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  logic [6:0] gly [8];
  int         t;
  logic [2:0] a_code [D];
  logic [2:0] p_code [D];
  logic [D-1:0] a_blk, p_blk;
  logic       p_flag;
  logic [6:0] e_seg;
  logic [D-1:0] e_an;

  initial begin
    int dig, ph;
    bit bnd;
    gly[0] = 7'h7F; gly[1] = 7'h08;
    gly[2] = 7'h42; gly[3] = 7'h3F;
    gly[4] = 7'h06; gly[5] = 7'h47;
    gly[6] = 7'h09; gly[7] = 7'h41;
    t = 0; p_flag = 0; a_blk = '0; p_blk = '0;
    for (int k = 0; k < D; k++) begin
      a_code[k] = '0; p_code[k] = '0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      chk("frame_start", 32'(frame_start),
          32'(!rst && (t % FL == FL - 1)));
      @(posedge clk);
      if (rst) begin
        t = 0; p_flag = 0; a_blk = '0; p_blk = '0;
        for (int k = 0; k < D; k++) begin
          a_code[k] = '0; p_code[k] = '0;
        end
        e_seg = 7'h7F; e_an = '1;
      end else begin
        dig = (t % FL) / SD;
`ifdef IRRIG_DISPLAY_BLINK_EN
        ph = ((t / FL) / BF) % 2;
`else
        ph = 0;
`endif
        e_an = ~(D'(1) << dig);
        e_seg = (ph == 1 && a_blk[dig]) ? 7'h7F : gly[a_code[dig]];
        bnd = (t % FL == FL - 1);
        if (bnd) begin
          if (load) begin
            for (int k = 0; k < D; k++) a_code[k] = codes[3*k +: 3];
            a_blk = blink;
          end else if (p_flag) begin
            for (int k = 0; k < D; k++) a_code[k] = p_code[k];
            a_blk = p_blk;
          end
          p_flag = 0;
        end else if (load) begin
          for (int k = 0; k < D; k++) p_code[k] = codes[3*k +: 3];
          p_blk = blink;
          p_flag = 1;
        end
        t++;
      end
      #1;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("pending", 32'(pending), 32'(p_flag));
      rst = (i < 2) || ($urandom % 500 == 0);
      if (!rst && (t % FL == FL - 1))
        load = ($urandom % 2 == 0);
      else
        load = ($urandom % 12 == 0);
      codes = 12'($urandom);
      blink = 4'($urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
